// File: rtl/fp_mac_acc.sv
`default_nettype none
// ============================================================================
// fp_mac_acc : frame accumulator for S(20,17) products, exact + rounded/sat out
// Revision   : 1.0
// ============================================================================
module fp_mac_acc #(
   parameter int NB_PROD  = 20,
   parameter int NBF_PROD = 17,
   parameter int NB_GUARD = 4,
   parameter int N_ACC    = 16,
   parameter int NB_OUT   = 12,
   parameter int NBF_OUT  = 11,
   localparam int NB_ACC  = NB_PROD + NB_GUARD,
   localparam int NB_CNT  = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
   input  logic                clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [NB_PROD-1:0]  i_prod,
   input  logic                i_clear,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [NB_ACC-1:0]   o_acc_full,
   output logic [NB_OUT-1:0]   o_acc_round_sat,
   output logic                o_sat,
   output logic [NB_CNT-1:0]   o_count
);

   localparam int NBF_ACC = NBF_PROD;
   localparam int c_SHIFT = NBF_ACC - NBF_OUT;
   localparam logic signed [NB_ACC:0] c_HALF =
      (c_SHIFT > 0) ? (NB_ACC+1)'(2**(c_SHIFT-1)) : '0;
   localparam logic signed [NB_ACC:0] c_MAX = (NB_ACC+1)'(2**(NB_OUT-1) - 1);
   localparam logic signed [NB_ACC:0] c_MIN = (NB_ACC+1)'(-(2**(NB_OUT-1)));
   localparam logic [NB_CNT-1:0]      c_LAST = NB_CNT'(N_ACC - 1);

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t                    r_state;
   logic signed [NB_ACC-1:0]  r_acc;
   logic [NB_CNT-1:0]         r_cnt;
   logic                      r_ready;
   logic                      r_valid;
   logic [NB_ACC-1:0]         r_full;
   logic [NB_OUT-1:0]         r_rs;
   logic                      r_sat;

   logic signed [NB_ACC-1:0]  w_sum;
   logic signed [NB_ACC:0]    w_rnd;
   logic signed [NB_ACC:0]    w_shr;
   logic signed [NB_ACC:0]    w_clip;
   logic                      w_sat;

   // Guard bits make this sum exact; rounding runs one bit wider to absorb the half-LSB add.
   always_comb begin
      w_sum  = r_acc + NB_ACC'($signed(i_prod));
      w_rnd  = {w_sum[NB_ACC-1], w_sum} + c_HALF;
      w_shr  = w_rnd >>> c_SHIFT;
      w_clip = w_shr;
      w_sat  = 1'b0;
      if (w_shr > c_MAX) begin
         w_clip = c_MAX;
         w_sat  = 1'b1;
      end else if (w_shr < c_MIN) begin
         w_clip = c_MIN;
         w_sat  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_ACC;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
         r_full  <= '0;
         r_rs    <= '0;
         r_sat   <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC: begin
               r_ready <= 1'b1;
               if (i_clear) begin
                  r_acc <= '0;
                  r_cnt <= '0;
               end else if (i_valid && r_ready) begin
                  if (r_cnt == c_LAST) begin
                     r_full  <= w_sum;
                     r_rs    <= w_clip[NB_OUT-1:0];
                     r_sat   <= w_sat;
                     r_valid <= 1'b1;
                     r_ready <= 1'b0;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_state <= ST_HOLD;
                  end else begin
                     r_acc <= w_sum;
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (i_ready) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_ACC;
               end
            end
            default: begin
               r_state <= ST_ACC;
               r_ready <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready         = r_ready;
   assign o_valid         = r_valid;
   assign o_acc_full      = r_full;
   assign o_acc_round_sat = r_rs;
   assign o_sat           = r_sat;
   assign o_count         = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_mac_acc.sv
`default_nettype none
// ============================================================================
// tb_fp_mac_acc : scoreboard bench for fp_mac_acc, directed frames
// Revision      : 1.0
// ============================================================================
module tb_fp_mac_acc;

   logic        clk;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [19:0] i_prod;
   logic        i_clear;
   logic        o_valid;
   logic        i_ready;
   logic [23:0] o_acc_full;
   logic [11:0] o_acc_round_sat;
   logic        o_sat;
   logic [3:0]  o_count;

   typedef struct packed {
      logic [23:0] full;
      logic [11:0] rs;
      logic        sat;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec;
   int   n_bad;

   fp_mac_acc dut (
      .clk             (clk),
      .i_rst_n         (i_rst_n),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_prod          (i_prod),
      .i_clear         (i_clear),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_acc_full      (o_acc_full),
      .o_acc_round_sat (o_acc_round_sat),
      .o_sat           (o_sat),
      .o_count         (o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted result is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (i_rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("acc_full", 32'(o_acc_full), 32'(e.full));
            check("acc_round_sat", 32'(o_acc_round_sat), 32'(e.rs));
            check("sat", 32'(o_sat), 32'(e.sat));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beats(input int n, input logic [19:0] val);
      for (int i = 0; i < n; i++) begin
         i_valid = 1'b1;
         i_prod  = val;
         tick();
      end
      i_valid = 1'b0;
      i_prod  = '0;
   endtask

   // One frame: first product, then 15 copies of rest; checks o_valid latency.
   task automatic send_frame(input logic [19:0] first, input logic [19:0] rest,
                             input logic [23:0] full, input logic [11:0] rs, input logic sat);
      exp_t e;
      e.full = full;
      e.rs   = rs;
      e.sat  = sat;
      exp_q.push_back(e);
      beats(1, first);
      beats(14, rest);
      check("valid_before_last", 32'(o_valid), 32'd0);
      beats(1, rest);
      check("valid_after_last", 32'(o_valid), 32'd1);
      check("ready_in_hold", 32'(o_ready), 32'd0);
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_ready"}, 32'(o_ready), 32'd0);
      check({tag, "_full"}, 32'(o_acc_full), 32'd0);
      check({tag, "_rs"}, 32'(o_acc_round_sat), 32'd0);
      check({tag, "_sat"}, 32'(o_sat), 32'd0);
      check({tag, "_count"}, 32'(o_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec   = 0;
      n_bad   = 0;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_prod  = '0;
      i_clear = 1'b0;
      i_ready = 1'b1;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'($urandom);
         i_prod  = 20'($urandom);
         i_clear = 1'($urandom);
         i_ready = 1'($urandom);
         tick();
         check_all_zero("reset");
      end
      i_valid = 1'b0;
      i_prod  = '0;
      i_clear = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      i_rst_n = 1'b1;
      tick();
      check("ready_after_reset", 32'(o_ready), 32'd1);
      check("count_after_reset", 32'(o_count), 32'd0);

      // Nominal, saturation and rounding frames
      send_frame(20'h00800, 20'h00800, 24'h008000, 12'h200, 1'b0);
      send_frame(20'h02000, 20'h02000, 24'h020000, 12'h7FF, 1'b1);
      send_frame(20'h80000, 20'h80000, 24'h800000, 12'h800, 1'b1);
      send_frame(20'h00020, 20'h00000, 24'h000020, 12'h001, 1'b0);
      send_frame(20'hFFFE0, 20'h00000, 24'hFFFFE0, 12'h000, 1'b0);
      send_frame(20'hFFFDF, 20'h00000, 24'hFFFFDF, 12'hFFF, 1'b0);
      check("count_mid", 32'(o_count), 32'd0);

      // Backpressure: result held while downstream stalls, no beats taken
      begin
         exp_t e;
         e.full = 24'h000400;
         e.rs   = 12'h010;
         e.sat  = 1'b0;
         exp_q.push_back(e);
         i_ready = 1'b0;
         beats(16, 20'h00040);
         i_valid = 1'b1;
         i_prod  = 20'h00800;
         for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_count", 32'(o_count), 32'd0);
            check("bp_full", 32'(o_acc_full), 32'h000400);
            check("bp_rs", 32'(o_acc_round_sat), 32'h010);
            tick();
         end
         i_valid = 1'b0;
         i_ready = 1'b1;
         tick();
         check("bp_valid_drop", 32'(o_valid), 32'd0);
         check("bp_ready_back", 32'(o_ready), 32'd1);
         check("bp_count_next", 32'(o_count), 32'd0);
      end

      // Clear at count 7 drops the partial sum and the concurrent beat
      beats(7, 20'h01000);
      check("count_before_clear", 32'(o_count), 32'd7);
      i_clear = 1'b1;
      i_valid = 1'b1;
      i_prod  = 20'h01000;
      tick();
      i_clear = 1'b0;
      i_valid = 1'b0;
      check("count_after_clear", 32'(o_count), 32'd0);
      send_frame(20'h00800, 20'h00800, 24'h008000, 12'h200, 1'b0);

      // Async reset mid-frame discards everything
      beats(9, 20'h00800);
      check("count_before_reset", 32'(o_count), 32'd9);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      tick();
      tick();
      @(negedge clk);
      i_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no_valid_after_reset", 32'(o_valid), 32'd0);
         check("count_zero_after_reset", 32'(o_count), 32'd0);
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
